// File: rtl/rom_upload_reader_if.sv
// rom_upload_reader_if: hps_io upload bus plus SDRAM read port of the ROM upload reader
// Signals: ioctl_upload/ioctl_rd/ioctl_addr/ioctl_din/ioctl_wait (hps_io side),
// port_req/port_ack/port_a/port_ds/port_we/port_q (SDRAM toggle handshake), rd_error.
// Macro ROM_UPLOAD_CHECKSUM_EN adds checksum[15:0].
// Modports: slave is the reader block, master is the hps_io/SDRAM environment.
interface rom_upload_reader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        port_req;
  logic        port_ack;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic        port_we;
  logic [15:0] port_q;
  logic        rd_error;
`ifdef ROM_UPLOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, port_ack, port_q,
    output ioctl_din, ioctl_wait, port_req, port_a, port_ds, port_we, rd_error
`ifdef ROM_UPLOAD_CHECKSUM_EN
    , output checksum
`endif
  );
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, port_ack, port_q,
    input  ioctl_din, ioctl_wait, port_req, port_a, port_ds, port_we, rd_error
`ifdef ROM_UPLOAD_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/rom_upload_reader.sv
// rom_upload_reader: serves hps_io upload byte reads from a one-word cache backed by an SDRAM req/ack port
// Ports: clk_sys, reset (async, active high), bus (rom_upload_reader_if.slave).
// Macro ROM_UPLOAD_CHECKSUM_EN adds a wrapping 16-bit sum of delivered bytes on bus.checksum.
module rom_upload_reader #(
  parameter logic [24:0] BASE_ADDR  = 25'h0000000,
  parameter logic [24:0] ADDR_LIMIT = 25'h001C320,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF,
  parameter int          TIMEOUT    = 1023
) (
  input logic clk_sys,
  input logic reset,
  rom_upload_reader_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {ALIGN, IDLE, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic ack_m_q, ack_s_q, rd_prev_q, upload_prev_q;
  logic [1:0] align_q, align_d;
  logic req_q, req_d, wait_q, wait_d, err_q, err_d, valid_q, valid_d, sel_q, sel_d;
  logic [7:0] din_q, din_d;
  logic [15:0] cache_q, cache_d;
  logic [22:0] tag_q, tag_d, pa_q, pa_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [23:0] sum;
  logic fire, oor, hit, miss, quick, ack_eq, up_fall, up_rise, tmo_hit, got, tout, din_ld;
  // Only bits [23:0] of the 25-bit sum reach port_a, so the carry out is never formed.
  assign sum     = bus.ioctl_addr[23:0] + BASE_ADDR[23:0];
  assign fire    = state_q == IDLE && bus.ioctl_upload && bus.ioctl_rd && !rd_prev_q;
  assign oor     = bus.ioctl_addr >= ADDR_LIMIT;
  assign hit     = valid_q && tag_q == sum[23:1];
  assign miss    = fire && !oor && !hit;
  assign quick   = fire && (oor || hit);
  assign ack_eq  = ack_s_q == req_q;
  assign up_fall = upload_prev_q && !bus.ioctl_upload;
  assign up_rise = !upload_prev_q && bus.ioctl_upload;
  assign tmo_hit = tmo_q == TW'(TIMEOUT);
  // An upload drop in WAIT abandons the fetch result: no data, no timeout, straight to DRAIN.
  assign got     = state_q == WAIT && !up_fall && ack_eq;
  assign tout    = state_q == WAIT && !up_fall && !ack_eq && tmo_hit;
  assign din_ld  = quick || got || tout;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= ALIGN;
      ack_m_q       <= 1'b0;
      ack_s_q       <= 1'b0;
      rd_prev_q     <= 1'b0;
      upload_prev_q <= 1'b0;
      align_q       <= 2'd0;
      req_q         <= 1'b0;
      wait_q        <= 1'b0;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
      sel_q         <= 1'b0;
      din_q         <= 8'h00;
      cache_q       <= 16'h0000;
      tag_q         <= 23'd0;
      pa_q          <= 23'd0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      ack_m_q       <= bus.port_ack;
      ack_s_q       <= ack_m_q;
      rd_prev_q     <= bus.ioctl_rd;
      upload_prev_q <= bus.ioctl_upload;
      align_q       <= align_d;
      req_q         <= req_d;
      wait_q        <= wait_d;
      err_q         <= err_d;
      valid_q       <= valid_d;
      sel_q         <= sel_d;
      din_q         <= din_d;
      cache_q       <= cache_d;
      tag_q         <= tag_d;
      pa_q          <= pa_d;
      tmo_q         <= tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ALIGN:   state_d = align_q == 2'd2 ? IDLE : ALIGN;
      IDLE:    state_d = miss ? WAIT : IDLE;
      WAIT:    state_d = up_fall ? DRAIN : ack_eq ? IDLE : tmo_hit ? DRAIN : WAIT;
      DRAIN:   state_d = ack_eq ? IDLE : DRAIN;
      default: state_d = ALIGN;
    endcase
  end
  // ALIGN copies ack_s into port_req so a stale ack left over from before reset never reads as a reply.
  always_comb begin
    align_d = state_q == ALIGN ? align_q + 2'd1 : 2'd0;
    req_d   = state_q == ALIGN ? ack_s_q : miss ? ~req_q : req_q;
    wait_d  = state_d == WAIT;
    din_d   = quick ? (oor ? FILL_BYTE : sum[0] ? cache_q[15:8] : cache_q[7:0]) :
              got   ? (sel_q ? bus.port_q[15:8] : bus.port_q[7:0]) :
              tout  ? FILL_BYTE : din_q;
    err_d   = tout || (err_q && !up_rise);
    cache_d = got ? bus.port_q : cache_q;
    tag_d   = got ? pa_q : tag_q;
    valid_d = (got || valid_q) && !tout && !up_fall;
    pa_d    = miss ? sum[23:1] : pa_q;
    sel_d   = miss ? sum[0] : sel_q;
    tmo_d   = miss ? '0 : (state_q == WAIT && !tmo_hit) ? tmo_q + TW'(1) : tmo_q;
  end
  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.port_req   = req_q;
  assign bus.port_a     = pa_q;
  assign bus.port_ds    = 2'b11;
  assign bus.port_we    = 1'b0;
  assign bus.rd_error   = err_q;
`ifdef ROM_UPLOAD_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;
  always_comb checksum_d = (up_rise ? 16'h0000 : checksum_q) + (din_ld ? {8'h00, din_d} : 16'h0000);
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) checksum_q <= 16'h0000;
    else checksum_q <= checksum_d;
  end
  assign bus.checksum = checksum_q;
`else
  logic unused_din_ld;
  assign unused_din_ld = din_ld;
`endif
endmodule

// File: tb/tb_rom_upload_reader.sv
// tb_rom_upload_reader: scoreboard bench for rom_upload_reader with a toggle-handshake SDRAM model
module tb_rom_upload_reader;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic hold = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  rom_upload_reader_if bus();
  rom_upload_reader dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));
  always #5 clk_sys = ~clk_sys;
  function automatic logic [15:0] mem(input logic [22:0] a);
    return a == 23'h4000 ? 16'hA55A : {a[7:0], a[15:8]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic rd_byte(input logic [24:0] a, input logic [7:0] e, output logic sw, output int n);
    @(negedge clk_sys);
    bus.ioctl_addr = a;
    bus.ioctl_rd = 1'b1;
    exp_q.push_back(e);
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    sw = bus.ioctl_wait;
    n = 0;
    while (bus.ioctl_wait && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (2) @(negedge clk_sys);
  endtask
  // SDRAM model: answers each request toggle 4 cycles later unless held off.
  initial begin
    bus.port_ack = 1'b1;
    bus.port_q = 16'h0000;
    forever begin
      @(negedge clk_sys);
      if (!reset && !hold && bus.port_req != bus.port_ack) begin
        repeat (4) @(negedge clk_sys);
        bus.port_q = mem(bus.port_a);
        bus.port_ack = bus.port_req;
      end
    end
  end
  // Monitor: sees each accepted read strobe and checks ioctl_din once the stall clears.
  initial begin
    logic rp;
    int k;
    logic [7:0] e;
    rp = 1'b0;
    forever begin
      @(posedge clk_sys);
      if (!reset && bus.ioctl_upload && bus.ioctl_rd && !rp) begin
        @(negedge clk_sys);
        k = 0;
        while (bus.ioctl_wait && k < 3000) begin
          @(negedge clk_sys);
          k++;
        end
        if (k >= 3000) chk("wait_bound", 32'(k), 32'd0);
        else if (exp_q.size() == 0) chk("unexpected_rd", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("ioctl_din", {24'h0, bus.ioctl_din}, {24'h0, e});
        end
      end
      rp = bus.ioctl_rd;
    end
  end
  initial begin
    logic sw, r0;
    int n, g;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = 25'h0;
    repeat (3) @(negedge clk_sys);
    chk("rst_din", {24'h0, bus.ioctl_din}, 32'h0);
    chk("rst_req", {31'h0, bus.port_req}, 32'h0);
    chk("rst_wait", {31'h0, bus.ioctl_wait}, 32'h0);
    chk("rst_err", {31'h0, bus.rd_error}, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    chk("align_req", {31'h0, bus.port_req}, 32'h1);
    chk("align_wait", {31'h0, bus.ioctl_wait}, 32'h0);
    chk("port_ds_we", {29'h0, bus.port_ds, bus.port_we}, 32'h6);
    bus.ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    rd_byte(25'h8000, 8'h5A, sw, n);
    chk("miss_wait", {31'h0, sw}, 32'h1);
    chk("miss_req", {31'h0, bus.port_req}, 32'h0);
    chk("miss_port_a", {9'h0, bus.port_a}, 32'h4000);
    r0 = bus.port_req;
    rd_byte(25'h8001, 8'hA5, sw, n);
    chk("hit_wait", {31'h0, sw}, 32'h0);
    chk("hit_req", {31'h0, bus.port_req}, {31'h0, r0});
    rd_byte(25'h1C320, 8'hFF, sw, n);
    chk("oor_wait", {31'h0, sw}, 32'h0);
    chk("oor_req", {31'h0, bus.port_req}, {31'h0, r0});
    rd_byte(25'h1C31F, 8'h8F, sw, n);
    chk("last_wait", {31'h0, sw}, 32'h1);
    rd_byte(25'h8002, 8'h40, sw, n);
    rd_byte(25'h8000, 8'h5A, sw, n);
    chk("evict_wait", {31'h0, sw}, 32'h1);
    hold = 1'b1;
    rd_byte(25'h10, 8'hFF, sw, n);
    chk("tmo_len", {31'h0, n >= 1023 && n <= 1025}, 32'h1);
    chk("tmo_err", {31'h0, bus.rd_error}, 32'h1);
    hold = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("drain_ack", {31'h0, bus.port_req == bus.port_ack}, 32'h1);
    chk("err_sticky", {31'h0, bus.rd_error}, 32'h1);
    bus.ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
    bus.ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("err_clear", {31'h0, bus.rd_error}, 32'h0);
    rd_byte(25'h8000, 8'h5A, sw, n);
    chk("post_drain_wait", {31'h0, sw}, 32'h1);
    hold = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h21;
    bus.ioctl_rd = 1'b1;
    exp_q.push_back(8'h5A);
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    chk("drop_wait_hi", {31'h0, bus.ioctl_wait}, 32'h1);
    repeat (4) @(negedge clk_sys);
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("drop_wait_lo", {31'h0, bus.ioctl_wait}, 32'h0);
    hold = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("drop_din", {24'h0, bus.ioctl_din}, 32'h5A);
    chk("drop_ack", {31'h0, bus.port_req == bus.port_ack}, 32'h1);
    bus.ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    rd_byte(25'h21, 8'h10, sw, n);
    chk("drop_remiss", {31'h0, sw}, 32'h1);
`ifdef ROM_UPLOAD_CHECKSUM_EN
    bus.ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
    bus.ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("csum_clear", {16'h0, bus.checksum}, 32'h0);
    rd_byte(25'h8000, 8'h5A, sw, n);
    rd_byte(25'h8001, 8'hA5, sw, n);
    rd_byte(25'h1C320, 8'hFF, sw, n);
    chk("checksum", {16'h0, bus.checksum}, 32'h01FE);
`endif
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk_sys);
      g++;
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rom_upload_reader.md
Name: rom_upload_reader

Overview:
- Read-back engine for the HPS ioctl upload path. It is the reader counterpart of the ROM download writer.
- Serves byte reads requested by hps_io while ioctl_upload is high.
- Fetches 16-bit words from an SDRAM port using the req/ack toggle handshake and returns the addressed byte on ioctl_din.
- Sits beside the download controller, sharing an SDRAM port when no download is active. Used for ROM verification dumps and hiscore/NVRAM save.

Parameters:
- BASE_ADDR, 25'h0000000: offset added to ioctl_addr before forming the SDRAM word address.
- ADDR_LIMIT, 25'h001C320: byte count readable; addresses at or above it return the fill byte.
- FILL_BYTE, 8'hFF: byte returned for out-of-range addresses.
- TIMEOUT, 1023: max cycles waiting for ack before abandoning the request.

Ports:
- clk_sys  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- ioctl_upload  in  1  upload session active
- ioctl_rd  in  1  byte read strobe from hps_io (level; edge-detected internally)
- ioctl_addr  in  25  byte address of the read
- ioctl_din  out  8  returned byte
- ioctl_wait  out  1  stall to hps_io while a fetch is outstanding
- port_req  out  1  request toggle to SDRAM port
- port_ack  in  1  ack toggle from SDRAM (other clock domain; synchronised here)
- port_a  out  23  word address = (ioctl_addr + BASE_ADDR)[23:1]
- port_ds  out  2  byte enables, constant 2'b11 for reads
- port_we  out  1  constant 0
- port_q  in  16  read word; stable once ack toggles
- rd_error  out  1  sticky timeout flag

Behaviour:
- Reset (async assert): port_req=0, ioctl_din=8'h00, ioctl_wait=0, rd_error=0, cache invalid, FSM=ALIGN.
- port_ack passes through a 2-flop synchroniser (ack_s). All comparisons use ack_s.
- ALIGN: entered after reset release. For 3 cycles port_req is loaded with ack_s, so a stale ack after reset causes no spurious handshake. Then IDLE.
- IDLE: a read fires when ioctl_upload=1, ioctl_rd=1 and ioctl_rd was 0 on the previous cycle (cycle N). ioctl_addr is latched at cycle N.
  - Out of range (addr >= ADDR_LIMIT): ioctl_din=FILL_BYTE at N+1; no request; ioctl_wait stays 0.
  - Cache hit (valid and cached word address == port_a): ioctl_din = addr[0] ? cache[15:8] : cache[7:0] at N+1; ioctl_wait stays 0.
  - Miss: at N+1 port_req toggles, ioctl_wait=1, FSM=WAIT, timeout counter cleared.
- WAIT:
  - The first cycle M where ack_s==port_req: latch port_q into the cache, mark it valid, and record the word address.
  - At M+1: ioctl_din = selected byte, ioctl_wait=0, FSM=IDLE.
  - Counter reaches TIMEOUT: rd_error=1, ioctl_din=FILL_BYTE, ioctl_wait=0, cache invalid, FSM=DRAIN.
- DRAIN: waits for ack_s==port_req without timing out, then returns to IDLE. New reads are ignored until then.
- ioctl_rd rising edge while not IDLE: ignored (hps_io is stalled by ioctl_wait; treated as protocol violation).
- ioctl_upload falling in WAIT: the request is not cancelled; data is discarded on ack, ioctl_wait drops immediately, FSM goes through DRAIN.
- ioctl_upload falling edge in any state: cache invalidated. rd_error is cleared on the next rising edge of ioctl_upload.
- Address arithmetic: 25-bit sum, upper bit dropped into 23-bit port_a. Wrap past 2^24 is not detected; ADDR_LIMIT must prevent it.
- port_req toggles exactly once per miss. Never toggles in IDLE, ALIGN or DRAIN.

Optional Feature:
- Macro: ROM_UPLOAD_CHECKSUM_EN.
- Defined:
  - Adds output checksum[15:0]: 16-bit wrapping sum of every byte delivered on ioctl_din, including FILL_BYTE.
  - Cleared on reset and on the ioctl_upload rising edge.
  - Updated the same cycle ioctl_din is updated.
- Undefined: the port is absent and no adder is generated.

Test Plan:
- Reset released with port_ack=1 held -> after ALIGN port_req=1; a later miss toggles it to 0; ioctl_wait does not assert before the first read.
- Word 0x4000 holds 16'hA55A, ack returned 4 cycles after req. Read addr 0x8000, then 0x8001 -> first read: ioctl_wait high, ioctl_din=8'h5A. Second read: cache hit at N+1, ioctl_din=8'hA5, port_req does not toggle.
- Read addr 0x1C320 -> ioctl_din=8'hFF at N+1, no req toggle, ioctl_wait stays 0.
- Ack withheld -> rd_error=1 after 1023 cycles, ioctl_din=8'hFF. Late ack accepted in DRAIN. Next upload session clears rd_error.
- ioctl_upload dropped mid-WAIT -> ioctl_wait=0 next cycle, ioctl_din unchanged when ack arrives, next read of the same address misses.
- With ROM_UPLOAD_CHECKSUM_EN, read bytes 0x5A,0xA5,0xFF -> checksum=16'h01FE.
